// File: rtl/dbus_arbiter_pkg.sv
// Shared constants and types for the data-bus arbiter and the data-memory model.
// Master IDs, the default slave read latency and the read-response tag type.
package dbus_arbiter_pkg;

  localparam logic DBUS_ARB_M0 = 1'b0;
  localparam logic DBUS_ARB_M1 = 1'b1;

  localparam int DBUS_ARB_RD_LAT = 1;

  typedef struct packed {
    logic valid;
    logic id;
  } rsp_tag_t;

endpackage

// File: rtl/dbus_arb_rsp_pipe.sv
// RD_LAT-deep shift register of read tags; out_o is the tag of the read issued RD_LAT cycles ago.
// One push per cycle (idle cycles push an invalid tag), no backpressure.
module dbus_arb_rsp_pipe
  import dbus_arbiter_pkg::*;
#(
  parameter int RD_LAT = DBUS_ARB_RD_LAT
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  rsp_tag_t push_i,
  output rsp_tag_t out_o
);

  rsp_tag_t pipe_q [RD_LAT];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= push_i;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign out_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master data-memory arbiter (CPU = m0, frame-buffer DMA = m1), zero-latency grant, read data routed back RD_LAT cycles later.
// Round-robin by default; DBUS_ARB_QOS_EN selects CPU priority with an m1 starvation bound. Grant holds while the slave stalls.
module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
  parameter int RD_LAT   = DBUS_ARB_RD_LAT,
  parameter int MAX_WAIT = 15
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        m0_cmd_valid_i,
  output logic        m0_cmd_ready_o,
  input  logic [31:0] m0_cmd_addr_i,
  input  logic        m0_cmd_we_i,
  input  logic [3:0]  m0_cmd_wstrb_i,
  input  logic [31:0] m0_wdata_i,
  output logic [31:0] m0_rdata_o,
  output logic        m0_rvalid_o,

  input  logic        m1_cmd_valid_i,
  output logic        m1_cmd_ready_o,
  input  logic [31:0] m1_cmd_addr_i,
  input  logic        m1_cmd_we_i,
  input  logic [3:0]  m1_cmd_wstrb_i,
  input  logic [31:0] m1_wdata_i,
  output logic [31:0] m1_rdata_o,
  output logic        m1_rvalid_o,

  output logic        s_cmd_valid_o,
  input  logic        s_cmd_ready_i,
  output logic [31:0] s_cmd_addr_o,
  output logic        s_cmd_we_o,
  output logic [3:0]  s_cmd_wstrb_o,
  output logic [31:0] s_wdata_o,
  input  logic [31:0] s_rdata_i,
  input  logic        s_rvalid_i,

  output logic        err_o
);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("dbus_arbiter: RD_LAT must be 1..4");
  end
  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("dbus_arbiter: MAX_WAIT must be 1..15");
  end

  logic     gnt_q, gnt_d;
  logic     hold_q, hold_d;
  logic     err_q, err_d;
  logic     grant;
  rsp_tag_t rsp_push;
  rsp_tag_t rsp_out;

`ifdef DBUS_ARB_QOS_EN
  localparam logic [3:0] MaxWaitC = 4'(MAX_WAIT);
  logic [3:0] wait_q, wait_d;
`endif

  // A command stalled by the slave keeps its grant until it transfers.
  always_comb begin
    grant = gnt_q;
    if (!hold_q) begin
`ifdef DBUS_ARB_QOS_EN
      if (m1_cmd_valid_i && (wait_q >= MaxWaitC)) begin
        grant = DBUS_ARB_M1;
      end else if (m0_cmd_valid_i) begin
        grant = DBUS_ARB_M0;
      end else if (m1_cmd_valid_i) begin
        grant = DBUS_ARB_M1;
      end
`else
      if (m0_cmd_valid_i && m1_cmd_valid_i) begin
        grant = ~gnt_q;
      end else if (m0_cmd_valid_i) begin
        grant = DBUS_ARB_M0;
      end else if (m1_cmd_valid_i) begin
        grant = DBUS_ARB_M1;
      end
`endif
    end
  end

  always_comb begin
    if (grant == DBUS_ARB_M1) begin
      s_cmd_valid_o = m1_cmd_valid_i;
      s_cmd_addr_o  = m1_cmd_addr_i;
      s_cmd_we_o    = m1_cmd_we_i;
      s_cmd_wstrb_o = m1_cmd_wstrb_i;
      s_wdata_o     = m1_wdata_i;
    end else begin
      s_cmd_valid_o = m0_cmd_valid_i;
      s_cmd_addr_o  = m0_cmd_addr_i;
      s_cmd_we_o    = m0_cmd_we_i;
      s_cmd_wstrb_o = m0_cmd_wstrb_i;
      s_wdata_o     = m0_wdata_i;
    end
  end

  assign m0_cmd_ready_o = s_cmd_ready_i & (grant == DBUS_ARB_M0) & m0_cmd_valid_i;
  assign m1_cmd_ready_o = s_cmd_ready_i & (grant == DBUS_ARB_M1) & m1_cmd_valid_i;

  assign gnt_d  = s_cmd_valid_o ? grant : gnt_q;
  assign hold_d = s_cmd_valid_o & ~s_cmd_ready_i;
  assign err_d  = err_q | (s_rvalid_i & ~rsp_out.valid);

  assign rsp_push.valid = s_cmd_valid_o & s_cmd_ready_i & ~s_cmd_we_o;
  assign rsp_push.id    = grant;

  dbus_arb_rsp_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rsp_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (rsp_push),
    .out_o  (rsp_out)
  );

  assign m0_rvalid_o = s_rvalid_i & rsp_out.valid & (rsp_out.id == DBUS_ARB_M0);
  assign m1_rvalid_o = s_rvalid_i & rsp_out.valid & (rsp_out.id == DBUS_ARB_M1);
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;
  assign err_o       = err_q;

`ifdef DBUS_ARB_QOS_EN
  // Saturating so a long slave stall cannot wrap the count back below the bound.
  always_comb begin
    wait_d = wait_q;
    if (!m1_cmd_valid_i || m1_cmd_ready_o) begin
      wait_d = '0;
    end else if ((grant != DBUS_ARB_M1) && (wait_q != 4'hF)) begin
      wait_d = wait_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`endif

  // gnt_q resets to m1 so that m0 wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt_q  <= DBUS_ARB_M1;
      hold_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      gnt_q  <= gnt_d;
      hold_q <= hold_d;
      err_q  <= err_d;
    end
  end

endmodule
